// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types for the modular exponentiation slice.
// FSM/op encodings, datapath widths and the 8x8 product helper.
package rsa_pkg;

    localparam int MOD_W  = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RED_RST,
        S_RED_RUN,
        S_NEXT,
        S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        OP_REDUCE_BASE,
        OP_SQUARE,
        OP_MULT
    } op_e;

    function automatic logic [PROD_W-1:0] mul8(
        input logic [MOD_W-1:0] a,
        input logic [MOD_W-1:0] b
    );
        return PROD_W'(a) * PROD_W'(b);
    endfunction

endpackage

// File: rtl/rsa_red_if.sv
// rsa_red_if: one-shot reduction sequencer.
// issue -> one reset cycle -> enable until ready, with a capture strobe.
module rsa_red_if
    import rsa_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             issue,
    input  logic             red_ready,
    input  logic [MOD_W-1:0] red_result,
    output logic             red_rst,
    output logic             red_enable,
    output logic             cap,
    output logic [MOD_W-1:0] cap_data
);

    logic rst_q, rst_d;
    logic en_q, en_d;

    assign cap        = en_q & red_ready;
    assign cap_data   = red_result;
    assign red_rst    = rst_q;
    assign red_enable = en_q;

    // enable follows the reset cycle, so ready seen here is always fresh
    always_comb begin
        rst_d = issue;
        en_d  = rst_q | (en_q & ~cap);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rst_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            rst_q <= rst_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/rsa_modexp.sv
// rsa_modexp: MSB-first square-and-multiply, base^exponent mod modulus.
// Products are formed here; each reduction goes to the external unit.
module rsa_modexp
    import rsa_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [MOD_W-1:0]  base,
    input  logic [EXP_W-1:0]  exponent,
    input  logic [MOD_W-1:0]  modulus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [MOD_W-1:0]  result,
    output logic [PROD_W-1:0] red_x,
    output logic [MOD_W-1:0]  red_y,
    output logic              red_enable,
    output logic              red_reset,
    input  logic [MOD_W-1:0]  red_result,
    input  logic              red_ready
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic [MOD_W-1:0]  base_q, base_d, mod_q, mod_d;
    logic [MOD_W-1:0]  acc_q, acc_d, bm_q, bm_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PROD_W-1:0] red_x_q, red_x_d;
    logic [MOD_W-1:0]  result_q, result_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic advance, issue, cap, red_rst;
    logic [MOD_W-1:0] cap_data;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign result    = result_q;
    assign red_x     = red_x_q;
    assign red_y     = mod_q;
    assign red_reset = reset | red_rst;
    assign issue     = (state_d == S_RED_RST);

    rsa_red_if u_red_if (
        .clock      (clock),
        .reset      (reset),
        .issue      (issue),
        .red_ready  (red_ready),
        .red_result (red_result),
        .red_rst    (red_rst),
        .red_enable (red_enable),
        .cap        (cap),
        .cap_data   (cap_data)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        acc_d    = acc_q;
        bm_d     = bm_q;
        idx_d    = idx_q;
        red_x_d  = red_x_q;
        result_d = result_q;
        busy_d   = busy_q;
        err_d    = err_q;
        done_d   = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            S_IDLE: if (start) begin
                base_d  = base;
                exp_d   = exponent;
                mod_d   = modulus;
                busy_d  = 1'b1;
                err_d   = 1'b0;
                idx_d   = IDX_TOP;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                unique case (1'b1)
                    (mod_q == '0): begin
                        err_d    = 1'b1;
                        acc_d    = '0;
                        result_d = '0;
                        state_d  = S_FINISH;
                    end
                    (mod_q == MOD_W'(1)): begin
                        acc_d    = '0;
                        result_d = '0;
                        state_d  = S_FINISH;
                    end
                    default: begin
                        op_d    = OP_REDUCE_BASE;
                        red_x_d = PROD_W'(base_q);
                        acc_d   = MOD_W'(1);
                        state_d = S_RED_RST;
                    end
                endcase
            end
            S_RED_RST: state_d = S_RED_RUN;
            S_RED_RUN: if (cap) begin
                if (op_q == OP_REDUCE_BASE) bm_d = cap_data;
                else                        acc_d = cap_data;
                state_d = S_NEXT;
            end
            S_NEXT: begin
                unique case (op_q)
                    OP_REDUCE_BASE: begin
                        op_d    = OP_SQUARE;
                        red_x_d = mul8(acc_q, acc_q);
                        state_d = S_RED_RST;
                    end
                    OP_SQUARE: if (exp_q[idx_q]) begin
                        op_d    = OP_MULT;
                        red_x_d = mul8(acc_q, bm_q);
                        state_d = S_RED_RST;
                    end else begin
                        advance = 1'b1;
                    end
                    default: advance = 1'b1;
                endcase
                if (advance) begin
                    if (idx_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        op_d    = OP_SQUARE;
                        red_x_d = mul8(acc_q, acc_q);
                        state_d = S_RED_RST;
                    end
                end
            end
            S_FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_REDUCE_BASE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            acc_q    <= '0;
            bm_q     <= '0;
            idx_q    <= '0;
            red_x_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            bm_q     <= bm_d;
            idx_q    <= idx_d;
            red_x_q  <= red_x_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: directed and random modexp checks.
// Includes a reduction unit model with random latency.
module tb_rsa_modexp;

    localparam int EXP_W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] base = '0;
    logic [7:0] modulus = '0;
    logic [EXP_W-1:0] exponent = '0;
    logic busy, done, err;
    logic [7:0] result;
    logic [15:0] red_x;
    logic [7:0] red_y;
    logic red_enable, red_reset;
    logic [7:0] red_result = '0;
    logic red_ready = 1'b0;

    int red_cnt = 0;
    int red_lat = 0;
    int rr_cnt = 0;
    int en_cnt = 0;
    int viol_cnt = 0;
    logic prev_en = 1'b0;
    logic [15:0] prev_x = '0;

    int tests_run = 0;
    int fails = 0;

    always #5 clock = ~clock;

    rsa_modexp #(.EXP_W(EXP_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base       (base),
        .exponent   (exponent),
        .modulus    (modulus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .result     (result),
        .red_x      (red_x),
        .red_y      (red_y),
        .red_enable (red_enable),
        .red_reset  (red_reset),
        .red_result (red_result),
        .red_ready  (red_ready)
    );

    // reduction unit: remainder after a random 0..3 cycle delay
    always @(posedge clock) begin
        if (red_reset) begin
            red_ready <= 1'b0;
            red_cnt   <= 0;
            red_lat   <= int'($urandom_range(0, 3));
        end else if (red_enable && !red_ready) begin
            if (red_cnt >= red_lat) begin
                red_ready  <= 1'b1;
                red_result <= (red_y == 0) ? 8'd0 : 8'(red_x % {8'd0, red_y});
            end else begin
                red_cnt <= red_cnt + 1;
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            if (red_reset) rr_cnt <= rr_cnt + 1;
            if (red_enable && !prev_en) en_cnt <= en_cnt + 1;
            if (red_reset && red_enable) viol_cnt <= viol_cnt + 1;
            if (red_enable && prev_en && red_x !== prev_x) viol_cnt <= viol_cnt + 1;
        end
        prev_en <= red_enable;
        prev_x  <= red_x;
    end

    function automatic logic [7:0] ref_modexp(input int b, input int e, input int m);
        int r, p, k;
        if (m <= 1) return 8'd0;
        r = 1;
        p = b % m;
        k = e;
        while (k != 0) begin
            if ((k & 1) != 0) r = (r * p) % m;
            p = (p * p) % m;
            k = k >> 1;
        end
        return 8'(r);
    endfunction

    function automatic int ref_reds(input logic [EXP_W-1:0] e, input logic [7:0] m);
        return (m > 1) ? 1 + EXP_W + $countones(e) : 0;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // starts one operation at the current negedge and waits for done
    task automatic run_op(
        input  logic [7:0]       b,
        input  logic [EXP_W-1:0] e,
        input  logic [7:0]       m,
        input  bit               spam,
        output logic [7:0]       res,
        output logic             er,
        output int               reds,
        output int               ens,
        output bit               got,
        output logic             bsy
    );
        int r0, e0;
        r0 = rr_cnt;
        e0 = en_cnt;
        got = 1'b0;
        base = b;
        exponent = e;
        modulus = m;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bsy = busy;
        for (int i = 0; i < 4000; i++) begin
            if (spam && i < 3) begin
                start = 1'b1;
                base = 8'($urandom);
                exponent = EXP_W'($urandom);
                modulus = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        res = result;
        er = err;
        reds = rr_cnt - r0;
        ens = en_cnt - e0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b want=0", done); end
        tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err); end
        tests_run++; if (result !== 8'd0) begin fails++; $display("FAIL reset_result got=%0d want=0", result); end
        tests_run++; if (red_x !== 16'd0) begin fails++; $display("FAIL reset_red_x got=%0d want=0", red_x); end
        tests_run++; if (red_enable !== 1'b0) begin fails++; $display("FAIL reset_red_en got=%b want=0", red_enable); end
        tests_run++; if (red_reset !== 1'b1) begin fails++; $display("FAIL reset_red_reset got=%b want=1", red_reset); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        run_op(8'd4, EXP_W'(13), 8'd7, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (got !== 1'b1) begin fails++; $display("FAIL basic_timeout got=%b want=1", got); end
        tests_run++; if (bsy !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b want=1", bsy); end
        tests_run++; if (res !== 8'd4) begin fails++; $display("FAIL basic_result got=%0d want=4", res); end
        tests_run++; if (er !== 1'b0) begin fails++; $display("FAIL basic_err got=%b want=0", er); end
        tests_run++; if (reds !== 12) begin fails++; $display("FAIL basic_reds got=%0d want=12", reds); end
        @(negedge clock);
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
        tests_run++; if (result !== 8'd4) begin fails++; $display("FAIL basic_hold got=%0d want=4", result); end
    endtask

    task automatic test_rsa();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        run_op(8'd9, EXP_W'(7), 8'd143, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd48 || got !== 1'b1) begin fails++; $display("FAIL rsa_enc got=%0d want=48", res); end
        tests_run++; if (reds !== 12) begin fails++; $display("FAIL rsa_enc_reds got=%0d want=12", reds); end
        idle(2);
        run_op(8'd48, EXP_W'(103), 8'd143, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd9 || got !== 1'b1) begin fails++; $display("FAIL rsa_dec got=%0d want=9", res); end
        tests_run++; if (reds !== 14) begin fails++; $display("FAIL rsa_dec_reds got=%0d want=14", reds); end
        idle(2);
    endtask

    task automatic test_exp_zero();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        run_op(8'd5, EXP_W'(0), 8'd11, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd1 || got !== 1'b1) begin fails++; $display("FAIL exp0_result got=%0d want=1", res); end
        tests_run++; if (reds !== 1 + EXP_W) begin fails++; $display("FAIL exp0_reds got=%0d want=%0d", reds, 1 + EXP_W); end
        idle(2);
    endtask

    task automatic test_special();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        run_op(8'd77, EXP_W'(200), 8'd1, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd0 || got !== 1'b1) begin fails++; $display("FAIL mod1_result got=%0d want=0", res); end
        tests_run++; if (er !== 1'b0) begin fails++; $display("FAIL mod1_err got=%b want=0", er); end
        tests_run++; if (ens !== 0) begin fails++; $display("FAIL mod1_enables got=%0d want=0", ens); end
        idle(2);
        run_op(8'd77, EXP_W'(200), 8'd0, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd0 || got !== 1'b1) begin fails++; $display("FAIL mod0_result got=%0d want=0", res); end
        tests_run++; if (er !== 1'b1) begin fails++; $display("FAIL mod0_err got=%b want=1", er); end
        tests_run++; if (ens !== 0) begin fails++; $display("FAIL mod0_enables got=%0d want=0", ens); end
        idle(3);
        tests_run++; if (err !== 1'b1) begin fails++; $display("FAIL mod0_err_hold got=%b want=1", err); end
        run_op(8'd3, EXP_W'(5), 8'd13, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd9 || er !== 1'b0) begin fails++; $display("FAIL after_err got=%0d/%b want=9/0", res, er); end
        idle(2);
    endtask

    task automatic test_busy_start();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        run_op(8'd48, EXP_W'(103), 8'd143, 1'b1, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd9 || got !== 1'b1) begin fails++; $display("FAIL busy_start_result got=%0d want=9", res); end
        tests_run++; if (reds !== 14) begin fails++; $display("FAIL busy_start_reds got=%0d want=14", reds); end
        idle(5);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_queued got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        run_op(8'd9, EXP_W'(7), 8'd143, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd48) begin fails++; $display("FAIL b2b_first got=%0d want=48", res); end
        run_op(8'd48, EXP_W'(103), 8'd143, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (bsy !== 1'b1) begin fails++; $display("FAIL b2b_accept got=%b want=1", bsy); end
        tests_run++; if (res !== 8'd9 || got !== 1'b1) begin fails++; $display("FAIL b2b_second got=%0d want=9", res); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] res; logic er, bsy; int reds, ens; bit got;
        bit saw_en;
        int dones;
        saw_en = 1'b0;
        dones = 0;
        base = 8'd48; exponent = EXP_W'(103); modulus = 8'd143; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (red_enable) begin
                saw_en = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++; if (saw_en !== 1'b1) begin fails++; $display("FAIL midrst_run got=%b want=1", saw_en); end
        reset = 1'b1;
        @(negedge clock);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b want=0", busy); end
        tests_run++; if (red_enable !== 1'b0) begin fails++; $display("FAIL midrst_en got=%b want=0", red_enable); end
        tests_run++; if (red_reset !== 1'b1) begin fails++; $display("FAIL midrst_red_reset got=%b want=1", red_reset); end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        tests_run++; if (dones !== 0) begin fails++; $display("FAIL midrst_done got=%0d want=0", dones); end
        run_op(8'd9, EXP_W'(7), 8'd143, 1'b0, res, er, reds, ens, got, bsy);
        tests_run++; if (res !== 8'd48 || got !== 1'b1) begin fails++; $display("FAIL midrst_after got=%0d want=48", res); end
        idle(2);
    endtask

    task automatic test_random();
        logic [7:0] b, m, res, want;
        logic [EXP_W-1:0] e;
        logic er, bsy;
        int reds, ens;
        bit got;
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom);
            e = EXP_W'($urandom);
            m = (n % 10 == 9) ? 8'((n / 10) % 2) : 8'($urandom_range(2, 255));
            want = ref_modexp(int'(b), int'(e), int'(m));
            run_op(b, e, m, 1'b0, res, er, reds, ens, got, bsy);
            tests_run++;
            if (got !== 1'b1 || res !== want) begin
                fails++;
                $display("FAIL rand_result b=%0d e=%0d m=%0d got=%0d want=%0d", b, e, m, res, want);
            end
            tests_run++;
            if (er !== (m == 8'd0)) begin
                fails++;
                $display("FAIL rand_err m=%0d got=%b want=%b", m, er, (m == 8'd0));
            end
            tests_run++;
            if (reds !== ref_reds(e, m)) begin
                fails++;
                $display("FAIL rand_reds e=%0d m=%0d got=%0d want=%0d", e, m, reds, ref_reds(e, m));
            end
            if (n % 3 == 0) idle(int'($urandom_range(0, 3)));
        end
        tests_run++;
        if (viol_cnt !== 0) begin
            fails++;
            $display("FAIL handshake_rules got=%0d violations want=0", viol_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rsa();
        test_exp_zero();
        test_special();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
- Square-and-multiply modular exponentiation controller: result = base^exponent mod modulus, 8-bit modulus.
- Initiator side of the team's iterative reduction handshake (x[15:0], y[7:0], enable, reset in; result[7:0], ready out).
- Computes every 8x8 product itself and issues each reduction to an external reduction unit.
- Sits between the RSA encrypt/decrypt top level and the reduction unit.

Parameters:
EXP_W, 8, exponent width in bits; one square step per exponent bit, MSB first.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
base  input  8  message/ciphertext operand
exponent  input  EXP_W  public or private exponent
modulus  input  8  n
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when result and err are valid
err  output  1  modulus==0 flag, valid with done, held until next start
result  output  8  final value, held until next accepted start
red_x  output  16  dividend to reduction unit; stable while red_enable high
red_y  output  8  divisor to reduction unit, always the latched modulus
red_enable  output  1  reduction unit enable
red_reset  output  1  reduction unit reset (reset OR internal pulse)
red_result  input  8  reduction unit remainder
red_ready  input  1  reduction unit completion, level, sticky until red_reset

Behaviour:
- Reset values: busy=0, done=0, err=0, result=0, red_x=0, red_enable=0. red_reset=1 whenever reset=1. FSM goes to IDLE, all operand latches cleared.
- States: IDLE, CHECK, RED_RST, RED_RUN, NEXT, FINISH.
- IDLE: on start=1, latch base, exponent, modulus; set busy=1, err=0; clear bit index to EXP_W-1; go to CHECK. start while busy is ignored, no queueing.
- CHECK: special cases.
  - modulus==0: err=1, result=0, go to FINISH.
  - modulus==1: result=0, go to FINISH.
  - Otherwise: op=REDUCE_BASE, red_x={8'd0,base}, acc=1, go to RED_RST.
- RED_RST: red_reset=1, red_enable=0 for exactly one cycle, then go to RED_RUN. Reset and enable are never high in the same cycle.
- RED_RUN:
  - red_enable=1; red_x held constant.
  - On red_ready=1: capture red_result into the destination of the current op, drop red_enable next cycle, go to NEXT.
  - red_ready cannot be stale, because the RED_RST cycle precedes RED_RUN.
- NEXT: sequences the ops after each reduction.
  - After REDUCE_BASE: bm = captured value; op=SQUARE, red_x = acc*acc.
  - After SQUARE: acc = captured value. If exponent[idx]=1: op=MULT, red_x = acc*bm. Else: advance idx.
  - After MULT: acc = captured value; advance idx.
  - Advancing idx: if idx==0 go to FINISH, else decrement idx, op=SQUARE, red_x = acc*acc, go to RED_RST.
- Arithmetic: products are full 16-bit unsigned (8x8). acc and bm are 8 bits and always < modulus. No truncation anywhere.
- FINISH:
  - result=acc, except in the special cases, where CHECK already set result.
  - done=1 for one cycle, busy=0, go to IDLE. A start in the cycle after FINISH is accepted.
- Reduction count, general case: 1 + EXP_W + popcount(exponent). Each reduction costs 2 + unit latency cycles, plus one NEXT cycle.
- exponent==0: result = 1 (modulus>1). All squarings of acc=1 still execute.
- Reset mid-operation: abort immediately, no done pulse. The reduction unit is reset in the same cycle via red_reset.

Decomposition:
- Shared package rsa_pkg: FSM state enum, op enum {REDUCE_BASE, SQUARE, MULT}, widths MOD_W=8, PROD_W=16.
- Sub-module rsa_red_if: the RED_RST/RED_RUN handshake sequencer (issue, wait, capture strobe), reusable by a future mod-multiply block.
- The reduction unit itself is external and not instantiated here; the bench provides a model.

Test Plan:
- base=4, exponent=13, modulus=7, EXP_W=8 -> done pulses once, result=4, err=0; exactly 1+8+3=12 red_reset pulses.
- RSA encrypt: base=9, exponent=7, modulus=143 -> result=48. Then decrypt: base=48, exponent=103, modulus=143 -> result=9.
- exponent=0, base=5, modulus=11 -> result=1.
- modulus=1 -> result=0, err=0, no red_enable ever. modulus=0 -> result=0, err=1, no red_enable.
- Second start pulse while busy -> ignored; result of the first operation unchanged.
- Reset asserted mid RED_RUN -> next cycle busy=0, red_enable=0, no done. A following start computes correctly.
